spi_tx_arbiter: RTL and testbench

- Shares one serial SPI link (cs/mosi on sclk) between NREQ requesters, each offering one DW-bit word.
- Round-robin arbiter plus frame sequencer on the master side of the link.
- Clocked directly by sclk, so frames come out at the standard frame format: cs low, DW data bits LSB-first, cs high.
- Drives the SPI slave receiver's cs/mosi inputs; the block that owns the system clock generates sclk.

---
 rtl/spi_tx_arbiter_if.sv | 28 ++
 rtl/spi_tx_arbiter.sv | 114 +++++++++++
 tb/tb_spi_tx_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_tx_arbiter_if.sv
// Requester-side bundle and SPI master pins for spi_tx_arbiter.
// Handshake: req[i] is a level the requester holds until it sees ack[i]. ack[i] is a
// one-cycle pulse issued when requester i's frame has fully left the link. grant[i] is
// high from the cs fall to that ack. din is sampled only on the edge that raises grant.
interface spi_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]         req;
  logic [NREQ*DW-1:0]      din;
  logic [NREQ-1:0]         grant;
  logic [NREQ-1:0]         ack;
  logic [$clog2(NREQ)-1:0] frame_id;
  logic                    busy;
  logic                    cs;
  logic                    mosi;
  logic [1:0]              dbg_state;

  modport master (
    input  req, din,
    output grant, ack, frame_id, busy, cs, mosi, dbg_state
  );

  modport slave (
    output req, din,
    input  grant, ack, frame_id, busy, cs, mosi, dbg_state
  );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter and frame sequencer sharing one SPI link between NREQ requesters.
// Runs on sclk; each frame is cs low, DW bits LSB-first, cs high, then GAP idle cycles.
module spi_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int GAP  = 1
) (
  input  logic             sclk,
  input  logic             rst,
  spi_tx_arbiter_if.master bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(DW + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  logic [1:0]      state;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [3:0]      gcnt;
  logic [DW-1:0]   shift;
  logic [NREQ-1:0] grant_r;
  logic [NREQ-1:0] ack_r;
  logic [IW-1:0]   fid_r;
  logic            cs_r;
  logic            mosi_r;

  logic [IW-1:0]   win;
  logic            found;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // First requester at or after the pointer, ascending with wrap.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req[rr_idx(ptr, i)]) begin
        win   = rr_idx(ptr, i);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      cnt     <= '0;
      gcnt    <= '0;
      shift   <= '0;
      grant_r <= '0;
      ack_r   <= '0;
      fid_r   <= '0;
      cs_r    <= 1'b1;
      mosi_r  <= 1'b0;
    end else begin
      ack_r <= '0;
      case (state)
        ST_IDLE: begin
          cs_r   <= 1'b1;
          mosi_r <= 1'b0;
          if (found) begin
            shift        <= bus.din[int'(win)*DW +: DW];
            grant_r      <= '0;
            grant_r[win] <= 1'b1;
            fid_r        <= win;
            cs_r         <= 1'b0;
            cnt          <= '0;
            state        <= ST_SEND;
          end
        end
        ST_SEND: begin
          mosi_r <= shift[0];
          shift  <= {1'b0, shift[DW-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(DW - 1)) state <= ST_STOP;
        end
        ST_STOP: begin
          cs_r       <= 1'b1;
          mosi_r     <= 1'b0;
          ack_r      <= grant_r;
          grant_r    <= '0;
          ptr        <= (fid_r == IW'(NREQ - 1)) ? '0 : fid_r + 1'b1;
          gcnt       <= '0;
          state      <= (GAP > 0) ? ST_GAP : ST_IDLE;
        end
        default: begin
          // Link idles with cs high; requests are not looked at until back in IDLE.
          cs_r   <= 1'b1;
          mosi_r <= 1'b0;
          gcnt   <= gcnt + 1'b1;
          if (gcnt == 4'(GAP - 1)) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.grant     = grant_r;
  assign bus.ack       = ack_r;
  assign bus.frame_id  = fid_r;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.cs        = cs_r;
  assign bus.mosi      = mosi_r;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Randomized bench for spi_tx_arbiter against a frame-timeline reference model.
module tb_spi_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int GAP  = 1;

  logic sclk;
  logic rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] din;
  logic [NREQ-1:0]    hold;

  spi_tx_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  assign bus.req = req;
  assign bus.din = din;

  spi_tx_arbiter #(.NREQ(NREQ), .DW(DW), .GAP(GAP)) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus)
  );

  // clock / reset
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is a fixed timeline measured from its grant edge k.
  int            cyc    = 0;
  bit            m_have = 0;
  int            m_k    = 0;
  int            m_win  = 0;
  int            m_fid  = 0;
  int            m_ptr  = 0;
  int            m_free = 0;
  logic [DW-1:0] m_data = '0;
  logic [DW+7:0] exp_q[$];

  task automatic model_edge();
    int  w;
    bit  hit;
    cyc++;
    if (rst) begin
      m_have = 0; m_ptr = 0; m_fid = 0; m_free = cyc + 1;
      exp_q.delete();
      return;
    end
    if (cyc >= m_free && req != '0) begin
      w = 0; hit = 0;
      for (int n = 0; n < NREQ; n++) begin
        if (!hit && req[(m_ptr + n) % NREQ]) begin
          w = (m_ptr + n) % NREQ; hit = 1;
        end
      end
      m_have = 1; m_k = cyc; m_win = w; m_fid = w;
      m_data = din[w*DW +: DW];
      m_ptr  = (w + 1) % NREQ;
      m_free = cyc + DW + GAP + 2;
      exp_q.push_back({8'(w), m_data});
    end
  endtask

  task automatic check_outputs();
    int              off;
    bit              in_frame;
    logic [NREQ-1:0] oh;
    logic            e_mosi;
    off      = cyc - m_k;
    in_frame = m_have && off <= DW;
    oh = '0;
    oh[m_win] = 1'b1;
    e_mosi = 1'b0;
    if (m_have && off >= 1 && off <= DW) e_mosi = m_data[off-1];
    check("cs", bus.cs, !in_frame);
    check("mosi", bus.mosi, e_mosi);
    check("grant", bus.grant, in_frame ? oh : '0);
    check("ack", bus.ack, (m_have && off == DW + 1) ? oh : '0);
    check("busy", bus.busy, m_have && off <= DW + GAP);
    check("frame_id", bus.frame_id, m_fid);
  endtask

  // scoreboard: rebuild each frame from the pins and match it on ack
  logic [DW-1:0] rx;
  int            rx_n = 0;
  bit            prev_cs_low = 0;

  task automatic monitor();
    logic [DW+7:0] e;
    int            idx;
    if (bus.cs == 1'b0 && prev_cs_low && rx_n < DW) begin
      rx[rx_n] = bus.mosi;
      rx_n++;
    end
    if (bus.cs == 1'b0 && !prev_cs_low) rx_n = 0;
    prev_cs_low = (bus.cs == 1'b0);
    if (bus.ack != '0) begin
      idx = 0;
      for (int i = 0; i < NREQ; i++) if (bus.ack[i]) idx = i;
      check("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_frame", {8'(idx), rx}, e);
        check("sb_bits", rx_n, DW);
      end
    end
  endtask

  // driver
  task automatic cycle();
    @(posedge sclk);
    model_edge();
    @(negedge sclk);
    check_outputs();
    monitor();
    for (int i = 0; i < NREQ; i++)
      if (!hold[i] && bus.ack[i]) req[i] = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_grant(input int i);
    int t;
    t = 0;
    while (bus.grant[i] !== 1'b1 && t < 40) begin
      cycle();
      t++;
    end
    check("grant_wait", bus.grant[i], 1'b1);
  endtask

  initial begin
    rst = 1'b1; req = '0; din = '0; hold = '0;
    run(3);
    rst = 1'b0;
    run(2);

    // single requester, A5
    din[0*DW +: DW] = 8'hA5;
    req = 4'b0001;
    run(14);

    // all four at once
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    run(50);

    // fairness with two permanent requesters
    hold = 4'b0101; req = 4'b0101;
    run(60);
    hold = '0; req = '0;
    run(15);

    // din change and req drop during own frame; req[3] pulsed and dropped before grant
    din[1*DW +: DW] = 8'h3C;
    req = 4'b0010;
    wait_grant(1);
    run(3);
    din[1*DW +: DW] = 8'hFF;
    req[1] = 1'b0;
    req[3] = 1'b1;
    run(2);
    req[3] = 1'b0;
    run(12);

    // reset mid-frame, then contention restarts from requester 0
    req = 4'b0100;
    wait_grant(2);
    run(4);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    req = 4'b1111;
    wait_grant(0);
    check("restart_winner", bus.frame_id, 0);
    run(50);

    // randomized traffic
    for (int t = 0; t < 500; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          din[i*DW +: DW] = DW'($urandom);
        end else if (req[i] && $urandom_range(0, 31) == 0) begin
          req[i] = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) din[i*DW +: DW] = DW'($urandom);
      end
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0; req = '0;
    run(20);
    check("sb_leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
